ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 17, RAM word-address width.
REQ-002 Parameter NB_COL, 4, byte lanes per word.
REQ-003 Parameter COL_WIDTH, 8, bits per lane; DATA_W = NB_COL*COL_WIDTH.
REQ-004 clk_i  in  1  single clock, all logic on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 busy_i  in  1  RAM owned by UART programmer or system reset active; blocks new grants.
REQ-007 if_req_i / if_addr_i  in  1 / ADDR_W  fetch read request and word address.
REQ-008 if_gnt_o  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid_o / if_rdata_o  out  1 / DATA_W  fetch read response.
REQ-010 d_req_i / d_we_i / d_addr_i  in  1 / 1 / ADDR_W  data request, write select, word address.
REQ-011 d_wdata_i / d_be_i  in  DATA_W / NB_COL  write data, byte enables.
REQ-012 d_gnt_o  out  1  data request accepted this cycle.
REQ-013 d_rvalid_o / d_rdata_o  out  1 / DATA_W  data response (read data, or write ack with zero data).
REQ-014 ram_rd_en_o / ram_rd_addr_o  out  1 / ADDR_W  RAM read port.
REQ-015 ram_wr_addr_o / ram_wr_data_o / ram_wr_strb_o  out  ADDR_W / DATA_W / NB_COL  RAM write port.
REQ-016 ram_rd_data_i  in  DATA_W  RAM read data, valid one cycle after ram_rd_en_o.

Function
REQ-017 At most one grant per cycle; grant combinational: requester selected, its req high, busy_i low.
REQ-018 Default priority fixed: data over fetch when both request.
REQ-019 Read grant: ram_rd_en_o=1, ram_rd_addr_o=granted address same cycle; ram_wr_strb_o=0.
REQ-020 Data write grant: ram_wr_addr_o=d_addr_i, ram_wr_data_o=d_wdata_i, ram_wr_strb_o=d_be_i same cycle; ram_rd_en_o=0.
REQ-021 No grant: ram_rd_en_o=0, ram_wr_strb_o=0; address/data outputs don't-care but stable (hold last).
REQ-022 Registered owner tag {NONE, IF, D_RD, D_WR} captured at grant; cleared to NONE when no grant.
REQ-023 Response exactly one cycle after grant: tag IF -> if_rvalid_o=1; D_RD or D_WR -> d_rvalid_o=1.
REQ-024 if_rdata_o / d_rdata_o = ram_rd_data_i when own rvalid and tag is read, else all zeros.
REQ-025 Fully pipelined: grant in cycle N and N+1 back-to-back permitted; response N+1 and N+2.
REQ-026 busy_i rising while a response is pending: pending response still delivered next cycle.
REQ-027 busy_i high: both gnt low, RAM strobes low, requests held by requester (not queued).
REQ-028 d_be_i=0 write: still granted and acked, RAM strobe 0.
REQ-029 Requester deasserting req without grant: no side effects.

Reset
REQ-030 rst_ni low: tag=NONE, if_rvalid_o=0, d_rvalid_o=0, rdata outputs 0, gnt outputs 0, RAM strobes 0, round-robin pointer = fetch-last (data wins first tie).
REQ-031 Reset during pending response: response dropped, no rvalid after release.

Configuration
REQ-032 Macro RAM_ARB_ROUND_ROBIN_EN defined: ties alternate; winner becomes lowest priority next contested cycle; pointer updates only on contested grant.
REQ-033 Macro undefined: fixed data-over-fetch priority per REQ-018, no pointer register.

Verification
REQ-034 Fetch read addr 0x10, RAM word 0x00000013 -> if_gnt_o same cycle, if_rvalid_o=1 next cycle, if_rdata_o=0x00000013.
REQ-035 Data write addr 0x20, data 0xDEADBEEF, be 0b0011 -> ram_wr_strb_o=0b0011 grant cycle; read 0x20 later returns 0x0000BEEF over zero-init RAM; d_rvalid_o ack with d_rdata_o=0.
REQ-036 Both request 4 cycles: macro off -> 4 data grants, fetch 0; macro on -> D,IF,D,IF.
REQ-037 busy_i high 3 cycles with both requests -> no grants, strobes 0; first grant cycle after busy_i falls.
REQ-038 Grant fetch read, assert rst_ni low before response cycle -> if_rvalid_o stays 0 after reset release.
REQ-039 Back-to-back data reads 0x1,0x2,0x3 -> three consecutive d_rvalid_o pulses, data in order.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester (fetch/data) arbiter for a single-cycle-latency RAM with a registered owner tag.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed data-over-fetch.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned NB_COL    = 4,
    parameter int unsigned COL_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          busy_i,

    input  logic                          if_req_i,
    input  logic [ADDR_W-1:0]             if_addr_i,
    output logic                          if_gnt_o,
    output logic                          if_rvalid_o,
    output logic [NB_COL*COL_WIDTH-1:0]   if_rdata_o,

    input  logic                          d_req_i,
    input  logic                          d_we_i,
    input  logic [ADDR_W-1:0]             d_addr_i,
    input  logic [NB_COL*COL_WIDTH-1:0]   d_wdata_i,
    input  logic [NB_COL-1:0]             d_be_i,
    output logic                          d_gnt_o,
    output logic                          d_rvalid_o,
    output logic [NB_COL*COL_WIDTH-1:0]   d_rdata_o,

    output logic                          ram_rd_en_o,
    output logic [ADDR_W-1:0]             ram_rd_addr_o,
    output logic [ADDR_W-1:0]             ram_wr_addr_o,
    output logic [NB_COL*COL_WIDTH-1:0]   ram_wr_data_o,
    output logic [NB_COL-1:0]             ram_wr_strb_o,
    input  logic [NB_COL*COL_WIDTH-1:0]   ram_rd_data_i
);

    localparam int unsigned DATA_W = NB_COL * COL_WIDTH;

    typedef enum logic [1:0] {TagNone, TagIf, TagDRd, TagDWr} tag_e;

    tag_e              tag_d, tag_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              arb_ok, d_win, if_win;

    assign arb_ok = rst_ni & ~busy_i;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Set when data won the last contested cycle, so fetch wins the next tie.
    logic rr_data_last_d, rr_data_last_q;

    assign d_win  = arb_ok & d_req_i  & (~if_req_i | ~rr_data_last_q);
    assign if_win = arb_ok & if_req_i & (~d_req_i  |  rr_data_last_q);

    always_comb begin
        rr_data_last_d = rr_data_last_q;
        if (arb_ok && if_req_i && d_req_i) begin
            rr_data_last_d = d_win;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_data_last_q <= 1'b0;
        end else begin
            rr_data_last_q <= rr_data_last_d;
        end
    end
`else
    assign d_win  = arb_ok & d_req_i;
    assign if_win = arb_ok & if_req_i & ~d_req_i;
`endif

    assign d_gnt_o  = d_win;
    assign if_gnt_o = if_win;

    always_comb begin
        tag_d         = TagNone;
        ram_rd_en_o   = 1'b0;
        ram_rd_addr_o = rd_addr_q;
        ram_wr_addr_o = wr_addr_q;
        ram_wr_data_o = wr_data_q;
        ram_wr_strb_o = '0;
        if (d_win) begin
            if (d_we_i) begin
                tag_d         = TagDWr;
                ram_wr_addr_o = d_addr_i;
                ram_wr_data_o = d_wdata_i;
                ram_wr_strb_o = d_be_i;
            end else begin
                tag_d         = TagDRd;
                ram_rd_en_o   = 1'b1;
                ram_rd_addr_o = d_addr_i;
            end
        end else if (if_win) begin
            tag_d         = TagIf;
            ram_rd_en_o   = 1'b1;
            ram_rd_addr_o = if_addr_i;
        end
    end

    // Address/data registers only keep the RAM port lines quiet between grants.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q     <= TagNone;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            tag_q     <= tag_d;
            rd_addr_q <= ram_rd_addr_o;
            wr_addr_q <= ram_wr_addr_o;
            wr_data_q <= ram_wr_data_o;
        end
    end

    always_comb begin
        if_rvalid_o = (tag_q == TagIf);
        d_rvalid_o  = (tag_q == TagDRd) || (tag_q == TagDWr);
        if_rdata_o  = (tag_q == TagIf)  ? ram_rd_data_i : '0;
        d_rdata_o   = (tag_q == TagDRd) ? ram_rd_data_i : '0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small zero-initialised byte-write RAM model.
module tb_ram_port_arbiter;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          busy = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [NB-1:0] d_be = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [NB-1:0] ram_wr_strb;
    logic [DW-1:0] ram_rd_data = '0;

    logic [DW-1:0] mem [256];

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_d;

    ram_port_arbiter #(.ADDR_W(AW), .NB_COL(NB), .COL_WIDTH(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .busy_i(busy),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_be_i(d_be), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr), .ram_wr_addr_o(ram_wr_addr),
        .ram_wr_data_o(ram_wr_data), .ram_wr_strb_o(ram_wr_strb), .ram_rd_data_i(ram_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr[7:0]];
        for (int b = 0; b < NB; b++) begin
            if (ram_wr_strb[b]) mem[ram_wr_addr[7:0]][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge, then settle combinational outputs.
    task automatic set_in(input logic ir, input logic [AW-1:0] ia, input logic dr,
                          input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                          input logic [NB-1:0] dbe, input logic b);
        @(negedge clk);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da;
        d_wdata = dwd; d_be = dbe; busy = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'h0000_0013;
        mem[8'h01] = 32'h1111_1111;
        mem[8'h02] = 32'h2222_2222;
        mem[8'h03] = 32'h3333_3333;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif

        // Reset state, with both requests asserted to confirm grants are held off.
        if_req = 1'b1; d_req = 1'b1;
        #12;
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_strb", ram_wr_strb, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch read of 0x10.
        set_in(1, 'h10, 0, 0, 0, 0, 0, 0);
        chk("if_gnt", if_gnt, 1);
        chk("if_d_gnt", d_gnt, 0);
        chk("if_rd_en", ram_rd_en, 1);
        chk("if_rd_addr", ram_rd_addr, 'h10);
        chk("if_strb", ram_wr_strb, 0);
        tick();
        chk("if_rvalid", if_rvalid, 1);
        chk("if_rdata", if_rdata, 32'h13);
        chk("if_d_rvalid", d_rvalid, 0);

        // Idle: no strobes, read address held.
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_gnt", {if_gnt, d_gnt}, 0);
        chk("idle_rd_en", ram_rd_en, 0);
        chk("idle_rd_addr_hold", ram_rd_addr, 'h10);
        tick();
        chk("idle_rvalid", {if_rvalid, d_rvalid}, 0);
        chk("idle_rdata", if_rdata, 0);

        // Partial write to 0x20, then read back.
        set_in(0, 0, 1, 1, 'h20, 32'hDEAD_BEEF, 4'b0011, 0);
        chk("wr_gnt", d_gnt, 1);
        chk("wr_strb", ram_wr_strb, 4'b0011);
        chk("wr_addr", ram_wr_addr, 'h20);
        chk("wr_data", ram_wr_data, 32'hDEAD_BEEF);
        chk("wr_rd_en", ram_rd_en, 0);
        tick();
        chk("wr_ack", d_rvalid, 1);
        chk("wr_ack_data", d_rdata, 0);
        set_in(0, 0, 1, 0, 'h20, 0, 0, 0);
        chk("rb_rd_en", ram_rd_en, 1);
        chk("rb_rd_addr", ram_rd_addr, 'h20);
        tick();
        chk("rb_rvalid", d_rvalid, 1);
        chk("rb_rdata", d_rdata, 32'h0000_BEEF);

        // Zero byte-enable write: acked, no strobe, memory untouched.
        set_in(0, 0, 1, 1, 'h21, 32'hFFFF_FFFF, 4'b0000, 0);
        chk("be0_gnt", d_gnt, 1);
        chk("be0_strb", ram_wr_strb, 0);
        tick();
        chk("be0_ack", d_rvalid, 1);
        set_in(0, 0, 1, 0, 'h21, 0, 0, 0);
        tick();
        chk("be0_rdata", d_rdata, 0);

        // Four contested cycles.
        for (int i = 0; i < 4; i++) begin
            set_in(1, 'h10, 1, 0, 'h1, 0, 0, 0);
            chk("tie_d_gnt", d_gnt, exp_d[i]);
            chk("tie_if_gnt", if_gnt, !exp_d[i]);
            tick();
            chk("tie_d_rvalid", d_rvalid, exp_d[i]);
            chk("tie_if_rvalid", if_rvalid, !exp_d[i]);
            chk("tie_rdata", exp_d[i] ? d_rdata : if_rdata, exp_d[i] ? 32'h1111_1111 : 32'h13);
        end

        // busy rises while the last tie response is visible; three blocked cycles.
        for (int i = 0; i < 3; i++) begin
            set_in(1, 'h10, 1, 0, 'h2, 0, 0, 1);
            if (i == 0) begin
                chk("busy_pend_d", d_rvalid, exp_d[3]);
                chk("busy_pend_if", if_rvalid, !exp_d[3]);
            end
            chk("busy_gnt", {if_gnt, d_gnt}, 0);
            chk("busy_rd_en", ram_rd_en, 0);
            chk("busy_strb", ram_wr_strb, 0);
            tick();
            chk("busy_rvalid", {if_rvalid, d_rvalid}, 0);
        end
        set_in(1, 'h10, 1, 0, 'h2, 0, 0, 0);
        chk("post_busy_d_gnt", d_gnt, 1);
        chk("post_busy_if_gnt", if_gnt, 0);
        tick();
        chk("post_busy_rdata", d_rdata, 32'h2222_2222);

        // Back-to-back data reads.
        for (int i = 1; i <= 3; i++) begin
            set_in(0, 0, 1, 0, AW'(i), 0, 0, 0);
            chk("b2b_gnt", d_gnt, 1);
            tick();
            chk("b2b_rvalid", d_rvalid, 1);
            chk("b2b_rdata", d_rdata, {4{8'(i * 8'h11)}});
        end

        // Reset between grant and response drops the response.
        set_in(1, 'h10, 0, 0, 0, 0, 0, 0);
        chk("rstp_gnt", if_gnt, 1);
        rst_n = 1'b0;
        #1;
        chk("rstp_gnt_gated", if_gnt, 0);
        if_req = 1'b0;
        tick();
        chk("rstp_rvalid_in_rst", if_rvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstp_rvalid_after", {if_rvalid, d_rvalid}, 0);
        chk("rstp_rdata_after", if_rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
